// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - funct codes and state encoding shared by the MDU sequencer
package mdu_pkg;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } mdu_state_e;

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one restoring-divide step: shift in a dividend bit, trial-subtract the divisor
module mdu_divstep #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             qbit_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   assign shifted = {rem_i, bit_i};
   assign diff    = shifted - {1'b0, divisor_i};

   // rem_i < divisor keeps shifted < 2*divisor, so the top bit of diff is a clean borrow flag
   assign qbit_o = ~diff[WIDTH];
   assign rem_o  = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative mult/div sequencer owning Hi/Lo, with pipeline stall generation
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [5:0]       Funct,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   input  logic             ReadReq,
   input  logic             Cancel,
   output logic             Stall,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_e         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               sign_a_q, sign_a_d;
   logic               sign_b_q, sign_b_d;
   logic               is_div_q, is_div_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dzf_q, dzf_d;

   logic               fn_mul, fn_div, fn_signed;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
   logic [WIDTH-1:0]   div_rem, quo_fix, rem_fix;
   logic               div_qbit;

   assign fn_mul    = (Funct == FN_MULT) || (Funct == FN_MULTU);
   assign fn_div    = (Funct == FN_DIV)  || (Funct == FN_DIVU);
   assign fn_signed = (Funct == FN_MULT) || (Funct == FN_DIV);
   assign a_neg     = fn_signed & OpA[WIDTH-1];
   assign b_neg     = fn_signed & OpB[WIDTH-1];
   assign a_mag     = a_neg ? (~OpA + 1'b1) : OpA;
   assign b_mag     = b_neg ? (~OpB + 1'b1) : OpB;

   // Multiply: acc holds {partial high, remaining multiplier bits}; add then shift right
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide: acc holds {remainder, dividend bits shifting out / quotient bits shifting in}
   mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
      .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
      .bit_i     (acc_q[WIDTH-1]),
      .divisor_i (opnd_q),
      .rem_o     (div_rem),
      .qbit_o    (div_qbit)
   );
   assign div_next = {div_rem, acc_q[WIDTH-2:0], div_qbit};

   assign prod_fix = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
   assign quo_fix  = (sign_a_q ^ sign_b_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
   assign rem_fix  = sign_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         is_div_q <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dzf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         is_div_q <= is_div_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dzf_q    <= dzf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      is_div_d = is_div_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dzf_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (Start && !Cancel) begin
               if (fn_mul) begin
                  state_d  = MUL;
                  cnt_d    = '0;
                  acc_d    = {{WIDTH{1'b0}}, b_mag};
                  opnd_d   = a_mag;
                  sign_a_d = a_neg;
                  sign_b_d = b_neg;
                  is_div_d = 1'b0;
                  dz_d     = 1'b0;
               end else if (fn_div && (OpB == '0)) begin
                  // Result is preloaded; FIX only publishes it
                  state_d  = FIX;
                  acc_d    = {OpA, {WIDTH{1'b1}}};
                  sign_a_d = 1'b0;
                  sign_b_d = 1'b0;
                  is_div_d = 1'b1;
                  dz_d     = 1'b1;
               end else if (fn_div) begin
                  state_d  = DIV;
                  cnt_d    = '0;
                  acc_d    = {{WIDTH{1'b0}}, a_mag};
                  opnd_d   = b_mag;
                  sign_a_d = a_neg;
                  sign_b_d = b_neg;
                  is_div_d = 1'b1;
                  dz_d     = 1'b0;
               end else if (Funct == FN_MTHI) begin
                  hi_d = OpA;
               end else if (Funct == FN_MTLO) begin
                  lo_d = OpA;
               end
            end
         end
         MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
         end
         DIV: begin
            acc_d = div_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (dz_q) begin
               hi_d  = acc_q[2*WIDTH-1:WIDTH];
               lo_d  = acc_q[WIDTH-1:0];
               dzf_d = 1'b1;
            end else if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase

      // A flush of the issuing instruction discards everything, including a pending FIX write
      if (Cancel && (state_q != IDLE)) begin
         state_d = IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
         dzf_d   = 1'b0;
      end
   end

   assign Busy      = (state_q != IDLE);
   assign Stall     = Busy & (Start | ReadReq);
   assign Done      = done_q;
   assign DivByZero = dzf_q;
   assign Hi        = hi_q;
   assign Lo        = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - scoreboard bench for the MDU sequencer with directed vectors
module tb_mdu_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Start = 1'b0;
   logic [5:0]  Funct = 6'h0;
   logic [31:0] OpA = 32'h0;
   logic [31:0] OpB = 32'h0;
   logic        ReadReq = 1'b0;
   logic        Cancel = 1'b0;
   logic        Stall, Busy, Done, DivByZero;
   logic [31:0] Hi, Lo;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [64:0] exp_q[$];
   logic [64:0] exp_e;

   mdu_sequencer #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .Start     (Start),
      .Funct     (Funct),
      .OpA       (OpA),
      .OpB       (OpB),
      .ReadReq   (ReadReq),
      .Cancel    (Cancel),
      .Stall     (Stall),
      .Busy      (Busy),
      .Done      (Done),
      .DivByZero (DivByZero),
      .Hi        (Hi),
      .Lo        (Lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every Done must match the oldest expected result
   always @(negedge clk) begin
      if (!reset) begin
         if (Done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'(Done), 64'd0);
            end else begin
               exp_e = exp_q.pop_front();
               check("done_hi", 64'(Hi), 64'(exp_e[63:32]));
               check("done_lo", 64'(Lo), 64'(exp_e[31:0]));
               check("done_dz", 64'(DivByZero), 64'(exp_e[64]));
            end
         end else if (DivByZero) begin
            check("dz_without_done", 64'(Done), 64'd1);
         end
      end
   end

   task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      Start = 1'b1; Funct = fn; OpA = a; OpB = b;
   endtask

   task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input int lat);
      int done_at = 0;
      int busy_n = 0;
      exp_q.push_back({edz, ehi, elo});
      issue(fn, a, b);
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (c == 1) Start = 1'b0;
         @(negedge clk);
         if (Busy) busy_n++;
         if (Done) begin
            done_at = c;
            break;
         end
      end
      check("latency", 64'(done_at), 64'(lat));
      check("busy_cycles", 64'(busy_n), 64'(lat - 1));
   endtask

   task automatic mt(input logic [5:0] fn, input logic [31:0] v);
      issue(fn, v, 32'h0);
      @(posedge clk); #1;
      Start = 1'b0;
      @(negedge clk);
      check("mt_busy", 64'(Busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check("rst_busy", 64'(Busy), 64'd0);
      check("rst_done", 64'(Done), 64'd0);
      check("rst_dz", 64'(DivByZero), 64'd0);
      check("rst_hi", 64'(Hi), 64'd0);
      check("rst_lo", 64'(Lo), 64'd0);
      check("rst_stall", 64'(Stall), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
      run_op(6'h18, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34);
      run_op(6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34);
      run_op(6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
      run_op(6'h1A, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0, 34);
      run_op(6'h1B, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 34);
      run_op(6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
      run_op(6'h1B, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 2);
      run_op(6'h1A, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2);

      mt(6'h11, 32'h0000DEAD);
      check("mthi_hi", 64'(Hi), 64'h0000DEAD);
      mt(6'h13, 32'h0000BEEF);
      check("mtlo_lo", 64'(Lo), 64'h0000BEEF);
      check("mtlo_hi_kept", 64'(Hi), 64'h0000DEAD);

      mt(6'h20, 32'h12345678);
      check("unknown_hi", 64'(Hi), 64'h0000DEAD);
      check("unknown_lo", 64'(Lo), 64'h0000BEEF);

      // Stall: ReadReq from N+5, stalled mtlo from N+10, both released in N+34
      exp_q.push_back({1'b0, 32'h00000001, 32'h00000003});
      issue(6'h1B, 32'h7, 32'h2);
      for (int c = 1; c <= 35; c++) begin
         @(posedge clk); #1;
         if (c == 1) Start = 1'b0;
         if (c == 5) ReadReq = 1'b1;
         if (c == 10) begin
            Start = 1'b1; Funct = 6'h13; OpA = 32'hAA;
         end
         if (c == 35) begin
            Start = 1'b0; ReadReq = 1'b0;
         end
         @(negedge clk);
         if (c <= 34) check("stall", 64'(Stall), 64'((c >= 5) && (c <= 33)));
         if (c == 34) check("stall_busy_low", 64'(Busy), 64'd0);
         if (c == 35) begin
            check("stalled_mtlo_lo", 64'(Lo), 64'hAA);
            check("stalled_mtlo_hi", 64'(Hi), 64'h1);
         end
      end

      mt(6'h11, 32'h5);
      mt(6'h13, 32'h5);
      issue(6'h1A, 32'd100, 32'd3);
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (c == 1) Start = 1'b0;
         if (c == 10) Cancel = 1'b1;
         if (c == 11) Cancel = 1'b0;
         @(negedge clk);
         if (c == 10) check("cancel_busy_before", 64'(Busy), 64'd1);
         if (c == 11) check("cancel_busy_after", 64'(Busy), 64'd0);
      end
      check("cancel_hi", 64'(Hi), 64'h5);
      check("cancel_lo", 64'(Lo), 64'h5);

      @(posedge clk); #1;
      Start = 1'b1; Funct = 6'h19; OpA = 32'h3; OpB = 32'h3; Cancel = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0; Cancel = 1'b0;
      @(negedge clk);
      check("cancel_idle_busy", 64'(Busy), 64'd0);

      // Cancel landing on the FIX cycle (N+33) must suppress the write
      issue(6'h19, 32'h3, 32'h3);
      for (int c = 1; c <= 36; c++) begin
         @(posedge clk); #1;
         if (c == 1) Start = 1'b0;
         if (c == 33) Cancel = 1'b1;
         if (c == 34) Cancel = 1'b0;
         @(negedge clk);
         if (c == 33) check("fix_cancel_busy_before", 64'(Busy), 64'd1);
         if (c == 34) begin
            check("fix_cancel_busy", 64'(Busy), 64'd0);
            check("fix_cancel_hi", 64'(Hi), 64'h5);
            check("fix_cancel_lo", 64'(Lo), 64'h5);
         end
      end

      issue(6'h19, 32'h2, 32'h2);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         if (c == 1) Start = 1'b0;
      end
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_busy", 64'(Busy), 64'd0);
      check("async_rst_hi", 64'(Hi), 64'd0);
      check("async_rst_lo", 64'(Lo), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 40; c++) @(negedge clk);
      check("async_rst_stays_idle", 64'(Busy), 64'd0);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
